// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default widths for the unified IF/DM memory arbiter.
package unified_mem_pkg;
  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data-stage and memory-side signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic [31:0]       perf_contend;
  logic [31:0]       perf_busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output perf_contend, perf_busy
  );

  // Pipeline stages and memory model side.
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  perf_contend, perf_busy
  );
endinterface

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// Saturating count of fetch losses; at_max forces the next contended win to IF.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && !at_max)    cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data stage.
// Define UNIFIED_MEM_ARB_PERF_EN to build the contention/busy performance counters.
module unified_mem_arbiter
  import unified_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  arb_state_t        state;
  owner_t            winner;
  logic              issue, atMax;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [BE_W-1:0]   memBe;
  logic [DATA_W-1:0] ifHeld, dmHeld;

  // DM has priority unless IF has lost STARVE_MAX contended rounds in a row.
  always_comb begin
    winner = OWN_DM;
    if (bus.if_req && (!bus.dm_req || atMax)) winner = OWN_IF;
  end

  assign bus.mem_req = reset && (state == ARB_IDLE) && (bus.if_req || bus.dm_req);
  assign issue       = bus.mem_req && bus.mem_gnt;
  assign bus.if_gnt  = issue && (winner == OWN_IF);
  assign bus.dm_gnt  = issue && (winner == OWN_DM);

  always_comb begin
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    memBe    = '0;
    if (bus.mem_req) begin
      if (winner == OWN_IF) begin
        memAddr = bus.if_addr;
        memBe   = '1;
      end else begin
        memWe    = bus.dm_we;
        memAddr  = bus.dm_addr;
        memWdata = bus.dm_wdata;
        memBe    = bus.dm_be;
      end
    end
  end

  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.mem_be    = memBe;

  // Response passes straight through in the mem_rvalid cycle; held copy covers later cycles.
  assign bus.if_rvalid = reset && (state == ARB_BUSY_IF) && bus.mem_rvalid;
  assign bus.dm_rvalid = reset && (state == ARB_BUSY_DM) && bus.mem_rvalid;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : ifHeld;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : dmHeld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ARB_IDLE;
      ifHeld <= '0;
      dmHeld <= '0;
    end else begin
      case (state)
        ARB_IDLE:
          if (issue) state <= (winner == OWN_IF) ? ARB_BUSY_IF : ARB_BUSY_DM;
        ARB_BUSY_IF:
          if (bus.mem_rvalid) begin
            ifHeld <= bus.mem_rdata;
            state  <= ARB_IDLE;
          end
        ARB_BUSY_DM:
          if (bus.mem_rvalid) begin
            dmHeld <= bus.mem_rdata;
            state  <= ARB_IDLE;
          end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (bus.dm_gnt && bus.if_req),
    .clr    (bus.if_gnt),
    .at_max (atMax)
  );

`ifdef UNIFIED_MEM_ARB_PERF_EN
  logic [31:0] contendCnt, busyCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contendCnt <= '0;
      busyCnt    <= '0;
    end else begin
      if ((state == ARB_IDLE) && bus.if_req && bus.dm_req) contendCnt <= contendCnt + 32'd1;
      if (state != ARB_IDLE)                               busyCnt    <= busyCnt + 32'd1;
    end
  end

  assign bus.perf_contend = contendCnt;
  assign bus.perf_busy    = busyCnt;
`else
  assign bus.perf_contend = '0;
  assign bus.perf_busy    = '0;
`endif
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified instruction/data memory between the fetch stage (IF, read-only) and the memory stage (DM, load/store). Selects one requester per transaction and allows one outstanding memory transaction. Routes the response back to the owner. The fetch and memory stages stall on their own gnt/rvalid, so the arbiter is the sequencing point for every memory access in the 5-stage pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (must be a multiple of 8)
STARVE_MAX, 4, consecutive IF losses under contention before IF is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
if_req  in  1  fetch read request; holds stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted by memory this cycle
if_rvalid  out  1  fetch read data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request; holds stable until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  store byte enables
dm_gnt  out  1  data request accepted by memory this cycle
dm_rvalid  out  1  load data / store ack valid (1-cycle pulse)
dm_rdata  out  DATA_W  load data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables (all ones for IF)
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response (read data or write ack)
mem_rdata  in  DATA_W  memory read data
perf_contend  out  32  contention-cycle counter (optional feature)
perf_busy  out  32  busy-cycle counter (optional feature)

Behaviour:
- FSM states: ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM. Reset state is ARB_IDLE. Registered starve_cnt and perf counters reset to 0.
- mem_req = reset && state==ARB_IDLE && (if_req || dm_req). All mem_* outputs are 0 when mem_req=0.
- Winner selection (combinational, ARB_IDLE only):
  - Only one requester active: that requester wins.
  - Both active: DM wins, unless starve_cnt==STARVE_MAX, in which case IF wins.
- Winner's addr/wdata/be/we drive mem_*. For IF: mem_we=0, mem_be all ones, mem_wdata=0.
- Issue: mem_req && mem_gnt. In that cycle, pulse the winner's gnt and move to ARB_BUSY_IF or ARB_BUSY_DM. If mem_gnt=0, stay in ARB_IDLE and re-arbitrate next cycle; the winner may change.
- Busy states: wait for mem_rvalid with no timeout.
  - On mem_rvalid, pulse the owner's rvalid in the same cycle (zero added latency) and return to ARB_IDLE.
  - Next issue is possible the following cycle, so the minimum transaction is 2 cycles.
- if_rdata and dm_rdata are registered and hold the last value delivered to that requester; rvalid still aligns with the mem_rvalid cycle. Implementation: rdata = rvalid ? mem_rdata : held.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each issue where dm wins while if_req=1.
  - Cleared on each IF issue.
  - Unchanged otherwise.
- mem_rvalid in ARB_IDLE is ignored: no rvalid pulse, no state change.
- Non-owner's gnt and rvalid stay 0 throughout a transaction. A new request arriving during busy waits.
- Reset asserted mid-transaction:
  - Immediately (asynchronously) returns to ARB_IDLE and drops the outstanding transaction.
  - All outputs go to 0. held rdata clears to 0.
  - A stale mem_rvalid after reset is ignored per the ARB_IDLE rule.
- Reset value of every output is 0.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_PERF_EN.
- Defined:
  - perf_contend increments every cycle with state==ARB_IDLE && if_req && dm_req.
  - perf_busy increments every cycle in ARB_BUSY_IF or ARB_BUSY_DM.
  - Both wrap at 2^32 and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package unified_mem_pkg holds:
  - arb_state_t enum (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM)
  - owner_t enum (OWN_IF, OWN_DM)
  - default width constants
- Sub-module arb_starve_ctr: saturating counter with inc, clr and at_max ports, parameterised by STARVE_MAX.

Test Plan:
- IF only, if_addr=0x100, mem_gnt=1, mem_rvalid two cycles later with mem_rdata=0x00500113 -> if_gnt in cycle 0; if_rvalid with if_rdata=0x00500113 in cycle 2; dm_gnt and dm_rvalid stay 0.
- if_req and dm_req (store, addr 0x2000, wdata 0xDEADBEEF, be 0xF) both rise together, starve_cnt=0 -> DM wins; mem_we=1 and mem_addr=0x2000; IF is granted at the first ARB_IDLE after dm_rvalid.
- Continuous IF and DM contention with STARVE_MAX=4 -> grant order DM, DM, DM, DM, IF, then DM again; starve_cnt returns to 0 after the IF grant.
- mem_gnt held 0 for 3 cycles with IF requesting -> mem_req=1 for 3 cycles, no if_gnt; if_gnt pulses on the first cycle with mem_gnt=1.
- Reset driven low while in ARB_BUSY_DM, then mem_rvalid=1 after reset released -> all outputs 0 during reset; state ARB_IDLE; no dm_rvalid pulse.
- With UNIFIED_MEM_ARB_PERF_EN: 5 contention cycles and 6 busy cycles -> perf_contend=5, perf_busy=6. Without the macro: both read 0.
